ame_num_accum: RTL and testbench

AME_NUM_ACCUM -- requirements
Module: ame_num_accum

---
 rtl/ame_num_accum.sv | 163 ++++++++++++++++
 tb/tb_ame_num_accum.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ame_num_accum.sv
// Block accumulator: sums signed samples until a "last" beat, then holds the
// sum, sample count, averaging shift and overflow flag for the normalizer.
module ame_num_accum #(
  parameter int COMP_DATA_BITS = 64,
  parameter int IN_DATA_BITS   = 32,
  parameter int CNT_BITS       = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic                              in_last_i,
  input  logic [IN_DATA_BITS-1:0]           in_data_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [COMP_DATA_BITS-1:0]         out_data_o,
  output logic [$clog2(COMP_DATA_BITS)-1:0] out_shift_o,
  output logic [CNT_BITS-1:0]               out_cnt_o,
  output logic                              out_ovf_o
);

  localparam int SHIFT_W = $clog2(COMP_DATA_BITS);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  function automatic logic signed [COMP_DATA_BITS-1:0] sign_ext(
    input logic signed [IN_DATA_BITS-1:0] x
  );
    return COMP_DATA_BITS'(x);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    if (&c) return c;
    return c + CNT_BITS'(1);
  endfunction

  // ceil(log2(c)) found as the bit length of c-1; counts 0 and 1 need no shift.
  function automatic logic [SHIFT_W-1:0] shift_for(input logic [CNT_BITS-1:0] c);
    logic [CNT_BITS-1:0] m;
    int r;
    m = c - CNT_BITS'(1);
    r = 0;
    for (int i = 0; i < CNT_BITS; i++) begin
      if (m[i]) r = i + 1;
    end
    if (c <= CNT_BITS'(1)) r = 0;
    if (r > COMP_DATA_BITS - 1) r = COMP_DATA_BITS - 1;
    return SHIFT_W'(r);
  endfunction

  state_t                            state_q, state_d;
  logic signed [COMP_DATA_BITS-1:0]  acc_q, acc_d;
  logic [CNT_BITS-1:0]               cnt_q, cnt_d;
  logic                              ovf_q, ovf_d;
  logic signed [COMP_DATA_BITS-1:0]  out_data_q, out_data_d;
  logic [SHIFT_W-1:0]                out_shift_q, out_shift_d;
  logic [CNT_BITS-1:0]               out_cnt_q, out_cnt_d;
  logic                              out_ovf_q, out_ovf_d;

  logic                              accept;
  logic signed [COMP_DATA_BITS-1:0]  ext;
  logic signed [COMP_DATA_BITS-1:0]  sum;
  logic                              add_ovf;
  logic [CNT_BITS-1:0]               cnt_inc;
  logic                              ovf_acc;

  assign in_ready_o  = (state_q == ST_ACC);
  assign out_valid_o = (state_q == ST_OUT);
  assign out_data_o  = out_data_q;
  assign out_shift_o = out_shift_q;
  assign out_cnt_o   = out_cnt_q;
  assign out_ovf_o   = out_ovf_q;

  // Accumulate stage: wrap-around add with signed-overflow detection.
  assign accept  = in_valid_i && (state_q == ST_ACC);
  assign ext     = sign_ext(in_data_i);
  assign sum     = acc_q + ext;
  assign add_ovf = (acc_q[COMP_DATA_BITS-1] == ext[COMP_DATA_BITS-1]) &&
                   (sum[COMP_DATA_BITS-1] != acc_q[COMP_DATA_BITS-1]);
  assign cnt_inc = sat_inc(cnt_q);
  assign ovf_acc = ovf_q | add_ovf;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_shift_d = out_shift_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;

    if (flush_i) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_data_d  = '0;
      out_shift_d = '0;
      out_cnt_d   = '0;
      out_ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_d = sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_acc;
            if (in_last_i) begin
              state_d     = ST_OUT;
              out_data_d  = sum;
              out_cnt_d   = cnt_inc;
              out_ovf_d   = ovf_acc;
              out_shift_d = shift_for(cnt_inc);
            end
          end
        end
        ST_OUT: begin
          // Result leaves on the handshake; the block restarts empty next cycle.
          if (out_ready_i) begin
            state_d     = ST_ACC;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_data_d  = '0;
            out_shift_d = '0;
            out_cnt_d   = '0;
            out_ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // Register stage: reset overrides flush and every handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_shift_q <= out_shift_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_ame_num_accum.sv
// Directed bench for ame_num_accum: default build, 64-bit input build and
// 4-bit counter build, all on one clock and one reset.
module tb_ame_num_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: defaults (64/32/16)
  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_in_last = 0;
  logic [31:0] a_in_data = '0;
  logic        a_out_valid, a_out_ready = 0, a_out_ovf;
  logic [63:0] a_out_data;
  logic [5:0]  a_out_shift;
  logic [15:0] a_out_cnt;

  // Instance B: 64-bit input samples
  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_in_last = 0;
  logic [63:0] b_in_data = '0;
  logic        b_out_valid, b_out_ready = 0, b_out_ovf;
  logic [63:0] b_out_data;
  logic [5:0]  b_out_shift;
  logic [15:0] b_out_cnt;

  // Instance C: 4-bit counter
  logic        c_flush = 0, c_in_valid = 0, c_in_ready, c_in_last = 0;
  logic [31:0] c_in_data = '0;
  logic        c_out_valid, c_out_ready = 0, c_out_ovf;
  logic [63:0] c_out_data;
  logic [5:0]  c_out_shift;
  logic [3:0]  c_out_cnt;

  ame_num_accum u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .in_valid_i(a_in_valid),
    .in_ready_o(a_in_ready), .in_last_i(a_in_last), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_shift_o(a_out_shift), .out_cnt_o(a_out_cnt), .out_ovf_o(a_out_ovf)
  );

  ame_num_accum #(.COMP_DATA_BITS(64), .IN_DATA_BITS(64), .CNT_BITS(16)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .in_last_i(b_in_last), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_shift_o(b_out_shift), .out_cnt_o(b_out_cnt), .out_ovf_o(b_out_ovf)
  );

  ame_num_accum #(.COMP_DATA_BITS(64), .IN_DATA_BITS(32), .CNT_BITS(4)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(c_flush), .in_valid_i(c_in_valid),
    .in_ready_o(c_in_ready), .in_last_i(c_in_last), .in_data_i(c_in_data),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
    .out_shift_o(c_out_shift), .out_cnt_o(c_out_cnt), .out_ovf_o(c_out_ovf)
  );

  // Drive one beat from a falling edge; returns at the falling edge after it is taken.
  task automatic a_send(input logic [31:0] d, input logic l);
    a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic b_send(input logic [63:0] d, input logic l);
    b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
    @(negedge clk);
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic c_send(input logic [31:0] d, input logic l);
    c_in_valid = 1'b1; c_in_data = d; c_in_last = l;
    @(negedge clk);
    c_in_valid = 1'b0; c_in_last = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    n_checks++; if (a_out_data !== 64'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", a_out_data); end
    n_checks++; if (a_out_shift !== 6'd0) begin n_fail++; $display("FAIL reset_out_shift got %0d want 0", a_out_shift); end
    n_checks++; if (a_out_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_out_cnt got %0d want 0", a_out_cnt); end
    n_checks++; if (a_out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got %b want 0", a_out_ovf); end
  endtask

  task automatic test_basic_sum;
    a_out_ready = 1'b1;
    a_send(32'd10, 1'b0);
    a_send(-32'sd3, 1'b0);
    a_send(32'd7, 1'b1);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready got %b want 0", a_in_ready); end
    n_checks++; if (a_out_data !== 64'd14) begin n_fail++; $display("FAIL basic_data got %0d want 14", a_out_data); end
    n_checks++; if (a_out_cnt !== 16'd3) begin n_fail++; $display("FAIL basic_cnt got %0d want 3", a_out_cnt); end
    n_checks++; if (a_out_shift !== 6'd2) begin n_fail++; $display("FAIL basic_shift got %0d want 2", a_out_shift); end
    n_checks++; if (a_out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", a_out_ovf); end
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after got %b want 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after got %b want 0", a_out_valid); end
    n_checks++; if (a_out_data !== 64'd0) begin n_fail++; $display("FAIL basic_data_cleared got %h want 0", a_out_data); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_single_negative;
    a_out_ready = 1'b0;
    a_send(-32'sd5, 1'b1);
    n_checks++; if (a_out_data !== 64'hFFFF_FFFF_FFFF_FFFB) begin n_fail++; $display("FAIL neg_data got %h want fffffffffffffffb", a_out_data); end
    n_checks++; if (a_out_cnt !== 16'd1) begin n_fail++; $display("FAIL neg_cnt got %0d want 1", a_out_cnt); end
    n_checks++; if (a_out_shift !== 6'd0) begin n_fail++; $display("FAIL neg_shift got %0d want 0", a_out_shift); end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL neg_ready_after got %b want 1", a_in_ready); end
  endtask

  task automatic test_hold_flush;
    a_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) a_send(32'(i), i == 5);
    // hold cycle 1
    n_checks++; if (a_out_data !== 64'd15) begin n_fail++; $display("FAIL hold1_data got %0d want 15", a_out_data); end
    n_checks++; if (a_out_cnt !== 16'd5) begin n_fail++; $display("FAIL hold1_cnt got %0d want 5", a_out_cnt); end
    n_checks++; if (a_out_shift !== 6'd3) begin n_fail++; $display("FAIL hold1_shift got %0d want 3", a_out_shift); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold1_ready got %b want 0", a_in_ready); end
    // input offered while holding must be ignored
    a_in_valid = 1'b1; a_in_data = 32'd99;
    @(negedge clk);
    // hold cycle 2, flush pulsed together with a handshake
    n_checks++; if (a_out_data !== 64'd15) begin n_fail++; $display("FAIL hold2_data got %0d want 15", a_out_data); end
    n_checks++; if (a_out_cnt !== 16'd5) begin n_fail++; $display("FAIL hold2_cnt got %0d want 5", a_out_cnt); end
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL hold2_valid got %b want 1", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold2_ready got %b want 0", a_in_ready); end
    a_in_valid = 1'b0;
    a_flush = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_flush = 1'b0; a_out_ready = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", a_in_ready); end
    n_checks++; if (a_out_data !== 64'd0) begin n_fail++; $display("FAIL flush_data got %h want 0", a_out_data); end
    n_checks++; if (a_out_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt got %0d want 0", a_out_cnt); end
    n_checks++; if (a_out_shift !== 6'd0) begin n_fail++; $display("FAIL flush_shift got %0d want 0", a_out_shift); end
  endtask

  task automatic test_flush_midblock;
    a_out_ready = 1'b0;
    a_send(32'd100, 1'b0);
    a_send(32'd200, 1'b0);
    // beat offered in the flush cycle is discarded
    a_flush = 1'b1;
    a_send(32'd50, 1'b1);
    a_flush = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mflush_valid got %b want 0", a_out_valid); end
    a_send(32'd6, 1'b1);
    n_checks++; if (a_out_data !== 64'd6) begin n_fail++; $display("FAIL mflush_data got %0d want 6", a_out_data); end
    n_checks++; if (a_out_cnt !== 16'd1) begin n_fail++; $display("FAIL mflush_cnt got %0d want 1", a_out_cnt); end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset_midblock;
    a_out_ready = 1'b0;
    a_send(32'd4, 1'b0);
    a_send(32'd4, 1'b0);
    rst = 1'b1;
    a_send(32'd9, 1'b1);
    rst = 1'b0;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", a_out_valid); end
    a_send(32'd4, 1'b0);
    a_send(32'd4, 1'b1);
    n_checks++; if (a_out_data !== 64'd8) begin n_fail++; $display("FAIL rstmid_data got %0d want 8", a_out_data); end
    n_checks++; if (a_out_cnt !== 16'd2) begin n_fail++; $display("FAIL rstmid_cnt got %0d want 2", a_out_cnt); end
    n_checks++; if (a_out_shift !== 6'd1) begin n_fail++; $display("FAIL rstmid_shift got %0d want 1", a_out_shift); end
    // reset while holding a result drops it without a handshake
    rst = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_out_ready = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstout_valid got %b want 0", a_out_valid); end
    n_checks++; if (a_out_data !== 64'd0) begin n_fail++; $display("FAIL rstout_data got %h want 0", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rstout_ready got %b want 1", a_in_ready); end
  endtask

  task automatic test_back_to_back;
    a_out_ready = 1'b1;
    a_send(32'd1, 1'b0);
    a_send(32'd2, 1'b1);
    a_in_valid = 1'b1; a_in_data = 32'd100; a_in_last = 1'b1;
    n_checks++; if (a_out_data !== 64'd3) begin n_fail++; $display("FAIL b2b_data1 got %0d want 3", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble_ready got %b want 0", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got %b want 0", a_out_valid); end
    a_in_data = 32'd5;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_last = 1'b0;
    n_checks++; if (a_out_data !== 64'd5) begin n_fail++; $display("FAIL b2b_data2 got %0d want 5", a_out_data); end
    n_checks++; if (a_out_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_cnt2 got %0d want 1", a_out_cnt); end
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    b_out_ready = 1'b0;
    b_send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    b_send(64'd1, 1'b1);
    n_checks++; if (b_out_data !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovf_data got %h want 8000000000000000", b_out_data); end
    n_checks++; if (b_out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", b_out_ovf); end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    b_send(64'd2, 1'b0);
    b_send(64'd3, 1'b1);
    n_checks++; if (b_out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag got %b want 0", b_out_ovf); end
    n_checks++; if (b_out_data !== 64'd5) begin n_fail++; $display("FAIL ovf_next_data got %0d want 5", b_out_data); end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    // negative overflow, then a later beat that cannot clear the sticky flag
    b_send(64'h8000_0000_0000_0000, 1'b0);
    b_send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    b_send(64'd1, 1'b1);
    n_checks++; if (b_out_data !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL novf_data got %h want 8000000000000000", b_out_data); end
    n_checks++; if (b_out_ovf !== 1'b1) begin n_fail++; $display("FAIL novf_flag got %b want 1", b_out_ovf); end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  task automatic test_count_saturate;
    c_out_ready = 1'b0;
    for (int i = 0; i < 20; i++) c_send(32'd1, i == 19);
    n_checks++; if (c_out_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt got %0d want 15", c_out_cnt); end
    n_checks++; if (c_out_data !== 64'd20) begin n_fail++; $display("FAIL sat_data got %0d want 20", c_out_data); end
    n_checks++; if (c_out_shift !== 6'd4) begin n_fail++; $display("FAIL sat_shift got %0d want 4", c_out_shift); end
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_single_negative();
    test_hold_flush();
    test_flush_midblock();
    test_reset_midblock();
    test_back_to_back();
    test_overflow();
    test_count_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
